// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the YCbCr -> RGB converter.
// Coefficients are the full-range BT.601 matrix scaled by 256.
package ycbcr_pkg;

  localparam int SUM_W      = 19;
  localparam int PIPE_DEPTH = 4;

  localparam int C_R_CR = 359;
  localparam int C_G_CB = 88;
  localparam int C_G_CR = 183;
  localparam int C_B_CB = 454;

  localparam int OFFSET = 128;
  localparam int ROUND  = 128;

  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [8:0]       chroma_t;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

endpackage

// File: rtl/ycbcr_clamp.sv
// Saturates a rounded 19-bit signed sum (value scaled by 256) to an 8-bit pixel.
module ycbcr_clamp
  import ycbcr_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum_i,
  output logic [7:0]              pix_o
);

  // Sign bit catches every negative result; bits above 15 flag values past 255.
  always_comb begin
    pix_o = sum_i[15:8];
    if (sum_i[SUM_W-1]) begin
      pix_o = 8'd0;
    end else if (|sum_i[SUM_W-2:16]) begin
      pix_o = 8'd255;
    end
  end

endmodule

// File: rtl/ycbcr2rgb.sv
// Free-running 4-stage full-range YCbCr -> RGB converter with sync/qualifier
// delay matched to the datapath; one sample per clock, never stalls.
module ycbcr2rgb
  import ycbcr_pkg::*;
#(
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vs,
  input  logic       i_hs,
  input  logic       i_de,
  input  logic [7:0] i_y,
  input  logic [7:0] i_cb,
  input  logic [7:0] i_cr,
  output logic       o_vs,
  output logic       o_hs,
  output logic       o_de,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  logic [7:0] yS1_q;
  chroma_t    cbOffS1_q, crOffS1_q;
  chroma_t    cbOffS1_d, crOffS1_d;

  sum_t yScaledS2_q, prodRCrS2_q, prodGCbS2_q, prodGCrS2_q, prodBCbS2_q;
  sum_t yScaledS2_d, prodRCrS2_d, prodGCbS2_d, prodGCrS2_d, prodBCbS2_d;

  sum_t sumRS3_q, sumGS3_q, sumBS3_q;
  sum_t sumRS3_d, sumGS3_d, sumBS3_d;

  logic [7:0] rS4_q, gS4_q, bS4_q;
  logic [7:0] rS4_d, gS4_d, bS4_d;
  logic [7:0] rClamp, gClamp, bClamp;

  sync_t syncPipe_q [PIPE_DEPTH];

  // Stage arithmetic: chroma offset, four chroma products plus 256*Y, rounded sums.
  always_comb begin
    cbOffS1_d   = chroma_t'({1'b0, i_cb} - 9'(OFFSET));
    crOffS1_d   = chroma_t'({1'b0, i_cr} - 9'(OFFSET));

    yScaledS2_d = sum_t'({3'b000, yS1_q, 8'h00});
    prodRCrS2_d = sum_t'(crOffS1_q) * sum_t'(C_R_CR);
    prodGCbS2_d = sum_t'(cbOffS1_q) * sum_t'(C_G_CB);
    prodGCrS2_d = sum_t'(crOffS1_q) * sum_t'(C_G_CR);
    prodBCbS2_d = sum_t'(cbOffS1_q) * sum_t'(C_B_CB);

    sumRS3_d    = yScaledS2_q + prodRCrS2_q + sum_t'(ROUND);
    sumGS3_d    = yScaledS2_q - prodGCbS2_q - prodGCrS2_q + sum_t'(ROUND);
    sumBS3_d    = yScaledS2_q + prodBCbS2_q + sum_t'(ROUND);
  end

  ycbcr_clamp uClampR (.sum_i(sumRS3_q), .pix_o(rClamp));
  ycbcr_clamp uClampG (.sum_i(sumGS3_q), .pix_o(gClamp));
  ycbcr_clamp uClampB (.sum_i(sumBS3_q), .pix_o(bClamp));

  // Blanking uses the qualifier that travels alongside stage 3's data.
  always_comb begin
    rS4_d = rClamp;
    gS4_d = gClamp;
    bS4_d = bClamp;
    if (BLANK_ZERO && !syncPipe_q[PIPE_DEPTH-2].de) begin
      rS4_d = 8'd0;
      gS4_d = 8'd0;
      bS4_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      yS1_q       <= '0;
      cbOffS1_q   <= '0;
      crOffS1_q   <= '0;
      yScaledS2_q <= '0;
      prodRCrS2_q <= '0;
      prodGCbS2_q <= '0;
      prodGCrS2_q <= '0;
      prodBCbS2_q <= '0;
      sumRS3_q    <= '0;
      sumGS3_q    <= '0;
      sumBS3_q    <= '0;
      rS4_q       <= '0;
      gS4_q       <= '0;
      bS4_q       <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) syncPipe_q[i] <= '0;
    end else begin
      yS1_q       <= i_y;
      cbOffS1_q   <= cbOffS1_d;
      crOffS1_q   <= crOffS1_d;
      yScaledS2_q <= yScaledS2_d;
      prodRCrS2_q <= prodRCrS2_d;
      prodGCbS2_q <= prodGCbS2_d;
      prodGCrS2_q <= prodGCrS2_d;
      prodBCbS2_q <= prodBCbS2_d;
      sumRS3_q    <= sumRS3_d;
      sumGS3_q    <= sumGS3_d;
      sumBS3_q    <= sumBS3_d;
      rS4_q       <= rS4_d;
      gS4_q       <= gS4_d;
      bS4_q       <= bS4_d;
      syncPipe_q[0] <= '{vs: i_vs, hs: i_hs, de: i_de};
      for (int i = 1; i < PIPE_DEPTH; i++) syncPipe_q[i] <= syncPipe_q[i-1];
    end
  end

  assign o_vs = syncPipe_q[PIPE_DEPTH-1].vs;
  assign o_hs = syncPipe_q[PIPE_DEPTH-1].hs;
  assign o_de = syncPipe_q[PIPE_DEPTH-1].de;
  assign o_r  = rS4_q;
  assign o_g  = gS4_q;
  assign o_b  = bS4_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: hand-computed vector table, a frame-style
// vs/de burst, and a mid-burst reset, all checked every cycle against a formula model.
module tb_ycbcr2rgb;

  typedef struct {
    logic [7:0] y, cb, cr;
    logic       de;
    logic [7:0] r, g, b;
  } vec_t;

  localparam int HIST = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
  logic [7:0] i_y = '0, i_cb = '0, i_cr = '0;
  logic       o_vs, o_hs, o_de;
  logic [7:0] o_r, o_g, o_b;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int vsCount = 0, vsEdge = -1, deCount = 0;
  int rstCyc = -100;

  logic [7:0] hY [HIST];
  logic [7:0] hCb [HIST];
  logic [7:0] hCr [HIST];
  logic       hVs [HIST];
  logic       hHs [HIST];
  logic       hDe [HIST];
  logic       hRst [HIST];
  int         hTbl [HIST];

  vec_t tbl [8];

  ycbcr2rgb #(.BLANK_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .i_y(i_y), .i_cb(i_cb), .i_cr(i_cr),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] clamp8(int v);
    int s;
    s = v >>> 8;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return s[7:0];
  endfunction

  function automatic logic [23:0] convert(logic [7:0] y, logic [7:0] cb, logic [7:0] cr);
    int yi, cbp, crp;
    yi  = int'(y);
    cbp = int'(cb) - 128;
    crp = int'(cr) - 128;
    return {clamp8(256*yi + 359*crp + 128),
            clamp8(256*yi - 88*cbp - 183*crp + 128),
            clamp8(256*yi + 454*cbp + 128)};
  endfunction

  task automatic compareVal(string name, int e, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, e, act, exp);
    end
  endtask

  // Output after edge e belongs to the input driven at edge e-4, and is only
  // valid if reset was released at every sampling edge along the way.
  task automatic checkOutput(int e);
    int src;
    logic valid;
    logic [26:0] exp, act;
    logic [23:0] rgb;
    src = e - 4;
    valid = (src >= 1);
    if (valid) for (int k = src; k < e; k++) if (!hRst[k]) valid = 1'b0;
    exp = '0;
    if (valid) begin
      rgb = hDe[src] ? convert(hY[src], hCb[src], hCr[src]) : 24'd0;
      exp = {hVs[src], hHs[src], hDe[src], rgb};
    end
    act = {o_vs, o_hs, o_de, o_r, o_g, o_b};
    compareVal("cycle_model", e, 32'(act), 32'(exp));
    if (valid && hTbl[src] >= 0)
      compareVal($sformatf("table_vec%0d", hTbl[src]), e, 32'({o_de, o_r, o_g, o_b}),
                 32'({tbl[hTbl[src]].de, tbl[hTbl[src]].r, tbl[hTbl[src]].g, tbl[hTbl[src]].b}));
    if (e == rstCyc + 4) compareVal("rst_still_blank", e, 32'(o_de), 32'd0);
    if (e == rstCyc + 5)
      compareVal("rst_first_pixel", e, 32'({o_de, o_r, o_g, o_b}),
                 32'({1'b1, convert(hY[rstCyc+1], hCb[rstCyc+1], hCr[rstCyc+1])}));
    if (o_vs) begin
      vsCount++;
      vsEdge = e;
    end
    if (o_de) deCount++;
  endtask

  task automatic applyStimulus(logic [7:0] y, logic [7:0] cb, logic [7:0] cr,
                               logic vs, logic hs, logic de, logic rstv, int tblIdx);
    @(posedge clk);
    cyc++;
    #1;
    i_y = y; i_cb = cb; i_cr = cr;
    i_vs = vs; i_hs = hs; i_de = de;
    rst_n = rstv;
    if (cyc < HIST) begin
      hY[cyc] = y; hCb[cyc] = cb; hCr[cyc] = cr;
      hVs[cyc] = vs; hHs[cyc] = hs; hDe[cyc] = de;
      hRst[cyc] = rstv; hTbl[cyc] = tblIdx;
    end
    @(negedge clk);
    checkOutput(cyc);
  endtask

  initial begin
    tbl[0] = '{y:8'd128, cb:8'd128, cr:8'd128, de:1'b1, r:8'd128, g:8'd128, b:8'd128};
    tbl[1] = '{y:8'd255, cb:8'd128, cr:8'd255, de:1'b1, r:8'd255, g:8'd164, b:8'd255};
    tbl[2] = '{y:8'd0,   cb:8'd0,   cr:8'd0,   de:1'b1, r:8'd0,   g:8'd136, b:8'd0};
    tbl[3] = '{y:8'd76,  cb:8'd85,  cr:8'd255, de:1'b1, r:8'd254, g:8'd0,   b:8'd0};
    tbl[4] = '{y:8'd100, cb:8'd200, cr:8'd50,  de:1'b1, r:8'd0,   g:8'd131, b:8'd228};
    tbl[5] = '{y:8'd50,  cb:8'd129, cr:8'd127, de:1'b1, r:8'd49,  g:8'd50,  b:8'd52};
    tbl[6] = '{y:8'd200, cb:8'd90,  cr:8'd170, de:1'b0, r:8'd0,   g:8'd0,   b:8'd0};
    tbl[7] = '{y:8'd16,  cb:8'd128, cr:8'd128, de:1'b1, r:8'd16,  g:8'd16,  b:8'd16};

    for (int k = 0; k < HIST; k++) begin
      hRst[k] = 1'b0; hTbl[k] = -1;
      hY[k] = '0; hCb[k] = '0; hCr[k] = '0;
      hVs[k] = 1'b0; hHs[k] = 1'b0; hDe[k] = 1'b0;
    end

    // Reset with busy inputs, then idle until the vs pulse at edge 10.
    for (int k = 1; k <= 3; k++) applyStimulus(8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    for (int k = 4; k <= 9; k++) applyStimulus(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(8'h40, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(8'h41, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    for (int i = 0; i < 1920; i++)
      applyStimulus(8'(i), 8'(i * 3), 8'(255 - i), 1'b0, 1'b0, 1'b1, 1'b1, -1);
    for (int k = 0; k < 10; k++)
      applyStimulus(8'(k * 7), 8'h55, 8'hAA, 1'b0, (k < 3), 1'b0, 1'b1, -1);
    compareVal("vs_pulse_count", cyc, 32'(vsCount), 32'd1);
    compareVal("vs_out_edge", cyc, 32'(vsEdge), 32'd14);
    compareVal("de_burst_len", cyc, 32'(deCount), 32'd1920);

    // Hand-computed table, back to back so consecutive samples are not merged.
    for (int i = 0; i < 8; i++)
      applyStimulus(tbl[i].y, tbl[i].cb, tbl[i].cr, 1'b0, 1'b0, tbl[i].de, 1'b1, i);
    for (int k = 0; k < 5; k++) applyStimulus(8'h00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, -1);

    // Single-cycle reset in the middle of a de burst.
    for (int j = 0; j < 20; j++) begin
      if (j == 10) rstCyc = cyc + 1;
      applyStimulus(8'(20 + j * 9), 8'(j * 13), 8'(200 - j * 5), 1'b0, 1'b0, 1'b1, (j != 10), -1);
    end
    for (int k = 0; k < 6; k++) applyStimulus(8'h00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
